// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and its downstream reset domains.
// The master modport is the sequencer; the slave modport is the set of domains returning acks.
interface reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4
) ();
  localparam int unsigned IdxW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [NUM_STAGES-1:0] i_ack;
  logic [NUM_STAGES-1:0] o_stage_rst;
  logic                  o_all_ready;
  logic                  o_fault;
  logic [IdxW-1:0]       o_stage_idx;
  logic                  o_drop;

  modport master (
    input  i_ack,
    output o_stage_rst,
    output o_all_ready,
    output o_fault,
    output o_stage_idx,
    output o_drop
  );

  modport slave (
    output i_ack,
    input  o_stage_rst,
    input  o_all_ready,
    input  o_fault,
    input  o_stage_idx,
    input  o_drop
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in index order with a fixed gap and per-stage ack timeout.
// Define RSTSEQ_ACK_SYNC_EN to pass every ack bit through a 2-flop synchronizer first.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned ACK_TIMEOUT  = 1024,
  parameter int unsigned RETRY_CYCLES = 256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  reset_sequencer_if.master seq_io
);
  localparam int unsigned IdxW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned MaxGA  = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int unsigned MaxCnt = (MaxGA > RETRY_CYCLES) ? MaxGA : RETRY_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_STAGES - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] AckLoad   = CntW'(ACK_TIMEOUT - 1);
  localparam logic [CntW-1:0] RetryLoad = CntW'(RETRY_CYCLES - 1);

  typedef enum logic [2:0] {StHold, StGap, StWait, StRun, StFault} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [NUM_STAGES-1:0] stage_rst_q;
  logic                  all_ready_q;
  logic                  fault_q;
  logic                  drop_q;

  logic [NUM_STAGES-1:0] ack;

`ifdef RSTSEQ_ACK_SYNC_EN
  logic [NUM_STAGES-1:0] ack_meta_q;
  logic [NUM_STAGES-1:0] ack_sync_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_meta_q <= '0;
      ack_sync_q <= '0;
    end else begin
      ack_meta_q <= seq_io.i_ack;
      ack_sync_q <= ack_meta_q;
    end
  end

  assign ack = ack_sync_q;
`else
  assign ack = seq_io.i_ack;
`endif

  // Stages already granted: everything below idx while sequencing, all of them in RUN.
  logic [NUM_STAGES-1:0] acked_mask;
  logic [NUM_STAGES-1:0] lost_vec;
  logic [NUM_STAGES-1:0] rerst_mask;
  logic [IdxW-1:0]       lost_idx;
  logic                  lost;

  always_comb begin
    acked_mask = '0;
    rerst_mask = '0;
    lost_idx   = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      if (state_q == StRun) begin
        acked_mask[k] = 1'b1;
      end else if ((state_q == StGap || state_q == StWait) && (k < int'(idx_q))) begin
        acked_mask[k] = 1'b1;
      end
    end
    lost_vec = ~ack & acked_mask;
    lost     = |lost_vec;
    for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
      if (lost_vec[k]) lost_idx = IdxW'(k);
    end
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      if (k >= int'(lost_idx)) rerst_mask[k] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
      all_ready_q <= 1'b0;
      fault_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (lost) begin
        stage_rst_q <= stage_rst_q | rerst_mask;
        idx_q       <= lost_idx;
        all_ready_q <= 1'b0;
        drop_q      <= 1'b1;
        state_q     <= StGap;
        cnt_q       <= GapLoad;
      end else begin
        case (state_q)
          StHold: begin
            state_q <= StGap;
            cnt_q   <= GapLoad;
          end
          StGap: begin
            if (cnt_q == '0) begin
              stage_rst_q[idx_q] <= 1'b0;
              cnt_q              <= AckLoad;
              state_q            <= StWait;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StWait: begin
            if (ack[idx_q]) begin
              if (idx_q == LastIdx) begin
                state_q     <= StRun;
                all_ready_q <= 1'b1;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= StGap;
                cnt_q   <= GapLoad;
              end
            end else if (cnt_q == '0) begin
              state_q     <= StFault;
              stage_rst_q <= '1;
              fault_q     <= 1'b1;
              idx_q       <= '0;
              cnt_q       <= RetryLoad;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StFault: begin
            if (cnt_q == '0) begin
              state_q <= StGap;
              cnt_q   <= GapLoad;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StRun: ;
          default: state_q <= StHold;
        endcase
      end
    end
  end

  assign seq_io.o_stage_rst = stage_rst_q;
  assign seq_io.o_all_ready = all_ready_q;
  assign seq_io.o_fault     = fault_q;
  assign seq_io.o_stage_idx = idx_q;
  assign seq_io.o_drop      = drop_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (3 stages, gap 4, timeout 8, retry 16).
// Expected output snapshots are queued with their edge number and checked on the falling edge.
module tb_reset_sequencer;
  localparam int unsigned NStg = 3;

  logic clk;
  logic rst;
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];

  reset_sequencer_if #(.NUM_STAGES(NStg)) sif ();

  reset_sequencer #(
    .NUM_STAGES  (NStg),
    .GAP_CYCLES  (4),
    .ACK_TIMEOUT (8),
    .RETRY_CYCLES(16)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .seq_io (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Snapshot layout: {stage_rst[2:0], all_ready, fault, stage_idx[1:0], drop}
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
      exp_t       e;
      logic [7:0] obs;
      e   = sb.pop_front();
      obs = {sif.o_stage_rst, sif.o_all_ready, sif.o_fault, sif.o_stage_idx, sif.o_drop};
      total++;
      assert (obs === e.v && e.cyc == edge_n)
      else begin
        bad++;
        $error("FAIL %s @edge %0d: got rst=%b rdy=%b flt=%b idx=%0d drop=%b, want %b (edge %0d)",
               e.tag, edge_n, obs[7:5], obs[4], obs[3], obs[2:1], obs[0], e.v, e.cyc);
      end
    end
  end

  task automatic expect_at(input int cyc, input string tag, input logic [2:0] r,
                           input logic rdy, input logic flt, input logic [1:0] idx,
                           input logic drp);
    exp_t e;
    e.cyc = cyc;
    e.tag = tag;
    e.v   = {r, rdy, flt, idx, drp};
    sb.push_back(e);
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  // Hold reset for 5 edges, check reset values, then release; b is the first edge sampling 0.
  task automatic start_seq(input logic [NStg-1:0] ack0, output int b);
    int e0;
    @(negedge clk);
    e0        = edge_n;
    rst       = 1'b1;
    sif.i_ack = ack0;
    expect_at(e0 + 5, "reset_vals", 3'b111, 1'b0, 1'b0, 2'd0, 1'b0);
    wait_edge(e0 + 5);
    rst = 1'b0;
    b   = e0 + 6;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst       = 1'b1;
    sif.i_ack = '0;

    // Normal sequence, acks 2 clocks after each release.
    start_seq(3'b000, b);
    expect_at(b + 3,  "s0_not_early", 3'b111, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_at(b + 4,  "s0_release",   3'b110, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_at(b + 7,  "s0_acked",     3'b110, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_at(b + 10, "s1_not_early", 3'b110, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_at(b + 11, "s1_release",   3'b100, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_at(b + 14, "s1_acked",     3'b100, 1'b0, 1'b0, 2'd2, 1'b0);
    expect_at(b + 18, "s2_release",   3'b000, 1'b0, 1'b0, 2'd2, 1'b0);
    expect_at(b + 20, "rdy_not_early", 3'b000, 1'b0, 1'b0, 2'd2, 1'b0);
    expect_at(b + 21, "all_ready",    3'b000, 1'b1, 1'b0, 2'd2, 1'b0);
    wait_edge(b + 6);  sif.i_ack = 3'b001;
    wait_edge(b + 13); sif.i_ack = 3'b011;
    wait_edge(b + 20); sif.i_ack = 3'b111;
    wait_edge(b + 22);

    // Stage 1 never acks: timeout, fault, retry from stage 0.
    start_seq(3'b000, b);
    expect_at(b + 18, "tmo_not_early", 3'b100, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_at(b + 19, "fault_entry",   3'b111, 1'b0, 1'b1, 2'd0, 1'b0);
    expect_at(b + 38, "retry_not_early", 3'b111, 1'b0, 1'b1, 2'd0, 1'b0);
    expect_at(b + 39, "retry_release", 3'b110, 1'b0, 1'b1, 2'd0, 1'b0);
    wait_edge(b + 6); sif.i_ack = 3'b001;
    wait_edge(b + 40);

    // All acks high from reset: releases still spaced gap+1 apart; then a dropped ack in RUN.
    start_seq(3'b111, b);
    expect_at(b + 4,  "early_s0",     3'b110, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_at(b + 8,  "early_gap1",   3'b110, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_at(b + 9,  "early_s1",     3'b100, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_at(b + 13, "early_gap2",   3'b100, 1'b0, 1'b0, 2'd2, 1'b0);
    expect_at(b + 14, "early_s2",     3'b000, 1'b0, 1'b0, 2'd2, 1'b0);
    expect_at(b + 15, "early_ready",  3'b000, 1'b1, 1'b0, 2'd2, 1'b0);
    expect_at(b + 18, "drop_pulse",   3'b110, 1'b0, 1'b0, 2'd1, 1'b1);
    expect_at(b + 19, "drop_one_clk", 3'b110, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_at(b + 22, "drop_reseq_s1", 3'b100, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_at(b + 28, "drop_ready",   3'b000, 1'b1, 1'b0, 2'd2, 1'b0);
    wait_edge(b + 17); sif.i_ack = 3'b101;
    wait_edge(b + 18); sif.i_ack = 3'b111;
    wait_edge(b + 29);

    // Ack arrives on the timeout edge, then reset asserted during stage 2 WAIT.
    start_seq(3'b000, b);
    expect_at(b + 11, "edge_wait",    3'b110, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_at(b + 12, "ack_beats_tmo", 3'b110, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_at(b + 16, "edge_s1",      3'b100, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_at(b + 22, "edge_s2",      3'b000, 1'b0, 1'b0, 2'd2, 1'b0);
    expect_at(b + 24, "s2_waiting",   3'b000, 1'b0, 1'b0, 2'd2, 1'b0);
    expect_at(b + 25, "mid_reset",    3'b111, 1'b0, 1'b0, 2'd0, 1'b0);
    wait_edge(b + 11); sif.i_ack = 3'b001;
    wait_edge(b + 17); sif.i_ack = 3'b011;
    wait_edge(b + 24); rst = 1'b1;
    wait_edge(b + 26); rst = 1'b0;
    wait_edge(b + 28);

    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the single power-on reset pulse from the delayed reset generator, configured active-high.
- Releases NUM_STAGES downstream reset domains one at a time, in index order: fixed gap before each release, then wait for that stage's ready/ack.
- On ack timeout or loss of a previously granted ack, re-asserts the affected resets and re-sequences from there.
- Single clock domain.

Parameters:
- NUM_STAGES, 4, number of sequenced reset outputs (1..16).
- GAP_CYCLES, 16, clocks between gap entry and the next stage release (>=1).
- ACK_TIMEOUT, 1024, clocks allowed for a released stage to raise its ack (>=1).
- RETRY_CYCLES, 256, clocks held in FAULT before retrying from stage 0 (>=1).

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset (from delayed reset generator).
- i_ack  input  NUM_STAGES  per-stage ready; bit k is meaningful only while stage k is released.
- o_stage_rst  output  NUM_STAGES  per-stage reset, active-high; bit k gates stage k.
- o_all_ready  output  1  all stages released and acked.
- o_fault  output  1  sticky: at least one ack timeout since the last i_reset.
- o_stage_idx  output  clog2(NUM_STAGES) (min 1)  stage currently being sequenced.
- o_drop  output  1  one-clock pulse when a granted ack is lost.

Behaviour:
- Reset is synchronous, active-high, and overrides everything. While i_reset=1, on every edge:
  - o_stage_rst = all ones; o_all_ready = 0; o_fault = 0; o_drop = 0; o_stage_idx = 0.
  - state = HOLD; counter = 0.
- Counter width is clog2 of max(GAP_CYCLES, ACK_TIMEOUT, RETRY_CYCLES) + 1. It counts down only and never wraps.
- Let "ack" be i_ack, or its synchronized copy when the optional feature below is enabled.
- HOLD:
  - The first edge with i_reset=0 moves to GAP with counter = GAP_CYCLES-1.
- GAP:
  - Decrement the counter each edge.
  - On the edge where counter==0: clear o_stage_rst[idx], load counter = ACK_TIMEOUT-1, go to WAIT.
  - Stage 0 reset therefore falls exactly GAP_CYCLES edges after the first edge that sampled i_reset=0.
- WAIT:
  - If ack[idx]=1: when idx==NUM_STAGES-1, go to RUN and set o_all_ready=1 on that edge. Otherwise idx+1 and GAP with counter = GAP_CYCLES-1.
  - Else if counter==0: go to FAULT.
  - Else: decrement the counter.
  - Ack wins over timeout on the same edge.
- FAULT:
  - o_stage_rst = all ones; o_fault = 1; idx = 0; counter = RETRY_CYCLES-1.
  - Decrement each edge. On counter==0, go to GAP with counter = GAP_CYCLES-1.
  - o_fault stays 1 until i_reset.
- Lost ack (checked in GAP, WAIT and RUN): applies when ack[j]=0 for any j already acked (j<idx, or any j in RUN).
  - Let m = lowest such j.
  - Set o_stage_rst[NUM_STAGES-1:m] = 1; idx = m; o_all_ready = 0; o_drop = 1 for one clock.
  - Go to GAP with counter = GAP_CYCLES-1.
  - Lost ack takes priority over ack/timeout evaluation on the same edge. It does not set o_fault.
- Overall priority: i_reset > lost ack > WAIT ack > timeout > count.
- Stage resets are only ever released in ascending order. Stage k+1 is never released while stage k is in reset.
- Mid-sequence i_reset returns everything to HOLD values on the same edge.
- Unreleased stages' acks are ignored, including spurious early highs.
- All outputs are registered; no combinational path from i_ack to any output.

Optional Feature:
- Macro: RSTSEQ_ACK_SYNC_EN.
- Defined: each i_ack bit passes through a 2-flop synchronizer, both flops cleared by i_reset, before any use. Ack and lost-ack responses occur 2 clocks later than without it. Timeout and gap counts are unchanged.
- Undefined: i_ack is sampled directly, and acks are required to be synchronous to i_clk.

Test Plan (NUM_STAGES=3, GAP_CYCLES=4, ACK_TIMEOUT=8, RETRY_CYCLES=16, macro undefined):
- Hold i_reset=1 for 5 clocks, then 0; acks rise 2 clocks after each release -> o_stage_rst goes 111→110 at edge 4, →100 at edge 4+3+4=11, →000 at edge 18; o_all_ready=1 at edge 21; o_stage_idx steps 0,1,2.
- Stage 1 ack never rises -> stage 1 reset released, FAULT 8 edges later: o_stage_rst=111 and o_fault=1. Re-release of stage 0 occurs 16+4 edges after FAULT entry; o_fault stays 1.
- In RUN, drop i_ack[1] for one clock -> one-clock o_drop; o_stage_rst=110; o_all_ready=0; o_stage_idx=1. Re-sequence restarts at stage 1; o_fault stays 0.
- Ack rises on the same edge the WAIT counter reaches 0 -> sequence advances, no FAULT.
- Assert i_reset during stage 2 WAIT -> next edge o_stage_rst=111, o_all_ready=0, o_fault=0, state HOLD.
- All i_ack held at 1 from time 0 -> stages still release spaced by GAP_CYCLES+1 edges, never simultaneously.
